clk_buff_sched: RTL and testbench
=================================

// Module: clk_buff_sched
// PURPOSE
//  Round-robin scheduler sharing one buffered clock resource between NREQ requesters.
//  - Grants the resource to one requester at a time.
//  - Emits a divided clock-enable strobe (buff_clk_en) that drives the clocked buffer.
//  - Releases the grant after a programmed number of strobes, or when the requester withdraws.
//  - Sits between requesting blocks and the clocked buffer, all in the master_clk domain.
// PARAMETERS
//  NREQ    4  number of requesters (>=2)
//  DIV_W   4  width of div_ratio; strobe period = div_ratio+1 cycles
//  HOLD_W  8  width of hold_cnt; strobes delivered per grant
// PORTS
//  master_clk   in   1       single clock; all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  req          in   NREQ    level request, one bit per requester
//  div_ratio    in   DIV_W   strobe divider, sampled on grant
//  hold_cnt     in   HOLD_W  strobes per grant, sampled on grant; 0 treated as 1
//  grant        out  NREQ    one-hot grant, registered
//  buff_clk_en  out  1       one-cycle enable strobe to the clocked buffer
//  busy         out  1       high in RUN and DRAIN
//  done         out  1       one-cycle pulse when a grant ends
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr_ptr=0, counters 0.
//  - FSM IDLE -> RUN -> DRAIN -> IDLE.
//  - IDLE, any req bit set:
//    - Pick the first set bit at or after rr_ptr (wrapping).
//    - Next cycle: grant one-hot, busy=1, state RUN.
//    - div_ratio and hold_cnt latched into internal registers.
//    - Grant latency is 1 cycle.
//  - RUN strobes:
//    - Divider counts 0..div_r; buff_clk_en=1 on the cycle the divider reaches div_r, then the divider wraps to 0.
//    - div_r=0 gives a strobe every cycle.
//    - Each strobe decrements the remaining count. The cycle after the final strobe: state DRAIN.
//  - RUN withdrawal:
//    - If the granted req bit drops, go to DRAIN next cycle; no further strobes.
//    - A strobe coincident with the drop is still issued.
//  - DRAIN (exactly 1 cycle):
//    - grant=0, buff_clk_en=0, done=1, busy=1.
//    - rr_ptr <= (granted index + 1) mod NREQ. Next state IDLE.
//  - Changes to div_ratio and hold_cnt during RUN are ignored.
//  - At least one IDLE cycle separates grants: a requester held high is re-granted only if it wins round-robin.
//  - Async rst mid-RUN: grant and buff_clk_en drop immediately; no done pulse.
//  - Invariants: grant is one-hot or zero; buff_clk_en is never high outside RUN.
// CONFIGURATION
//  `CLK_BUFF_SCHED_PHASE_ALIGN_EN
//   - Defined: the divider preloads to div_r on grant, so the first strobe occurs on the first RUN cycle. buff_clk_en is then phase-aligned to the grant edge.
//   - Undefined: the divider starts at 0, so the first strobe occurs div_r cycles after entering RUN.
// STRUCTURE
//  - Shared package clk_buff_pkg:
//    - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DRAIN=2'd2
//    - function rr_pick(req, ptr) returning the winning index
//  - Sub-module clk_buff_div: divider counter with load/enable and terminal strobe, reusable by the buffer datapath.
//  - Top level holds the FSM, rr_ptr, hold counter and the grant register.
// TESTING
//  1. Single req[1]=1, div_ratio=2, hold_cnt=3:
//     grant=0010 one cycle later; 3 strobes spaced 3 cycles apart; done pulse; grant=0.
//  2. req=1111 held, hold_cnt=1, div_ratio=0:
//     grants rotate 0001,0010,0100,1000,0001; each followed by done then 1 IDLE cycle.
//  3. Withdrawal: hold_cnt=10, drop req after 2 strobes:
//     DRAIN next cycle; exactly 2 strobes total; done=1.
//  4. hold_cnt=0, div_ratio=0:
//     exactly 1 strobe; done follows.
//  5. Assert rst mid-RUN:
//     grant, buff_clk_en and busy go 0 without waiting for a clock edge; next grant goes to the lowest set req (rr_ptr=0).
//  6. Build with and without the macro, div_ratio=3:
//     first strobe at RUN cycle 0 (macro defined) vs cycle 3 (undefined); period 4 in both builds.

Source files
------------

// File: rtl/clk_buff_pkg.sv
// Shared definitions for the buffered-clock scheduler.
//   - State encoding (S_IDLE/S_RUN/S_DRAIN) and the matching typed enum.
//   - rr_pick(): round-robin winner search over up to MaxReq requesters.
package clk_buff_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StRun   = S_RUN,
    StDrain = S_DRAIN
  } state_e;

  // Upper bound on requesters; request vectors are zero-extended to this width.
  localparam int unsigned MaxReq = 32;
  localparam int unsigned IdxW   = 5;

  // Returns the first set bit at or after ptr, wrapping at nreq. Returns ptr
  // when no bit is set (caller only uses the result when some bit is set).
  function automatic logic [IdxW-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                               input logic [IdxW-1:0]   ptr,
                                               input int unsigned       nreq);
    logic        found;
    int unsigned j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < nreq) begin
        j = int'(ptr) + i;
        if (j >= nreq) j = j - nreq;
        if (!found && req[j]) begin
          found   = 1'b1;
          rr_pick = IdxW'(j);
        end
      end
    end
  endfunction

endpackage

// File: rtl/clk_buff_sched_div.sv
// Divider counter with load/enable and terminal strobe.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   load_i        : load cnt with load_val_i (has priority over en_i)
//   en_i          : count enable; counter runs 0..limit_i then wraps to 0
//   limit_i       : terminal count
//   strobe_o      : high while enabled and the counter sits at limit_i
module clk_buff_div #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         strobe_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign strobe_o = en_i && (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = strobe_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clk_buff_sched.sv
// Round-robin scheduler sharing one buffered clock resource between NREQ
// requesters. One grant at a time; while granted, emits a divided enable
// strobe and releases after hold_cnt strobes or when the requester withdraws.
//   master_clk, rst : clock, asynchronous active-high reset
//   req             : level requests
//   div_ratio       : strobe period - 1, latched at grant
//   hold_cnt        : strobes per grant (0 acts as 1), latched at grant
//   grant           : registered one-hot grant
//   buff_clk_en     : one-cycle enable strobe to the clocked buffer
//   busy            : high in RUN and DRAIN
//   done            : one-cycle pulse in DRAIN
// Build option: CLK_BUFF_SCHED_PHASE_ALIGN_EN preloads the divider so the
// first strobe lands on the first RUN cycle.
module clk_buff_sched
  import clk_buff_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DIV_W  = 4,
  parameter int unsigned HOLD_W = 8
) (
  input  logic              master_clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [DIV_W-1:0]  div_ratio,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic [NREQ-1:0]   grant,
  output logic              buff_clk_en,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     pick;
  logic [DIV_W-1:0]    div_r_q, div_r_d;
  logic [DIV_W-1:0]    div_preload;
  logic [HOLD_W-1:0]   rem_q, rem_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [MaxReq-1:0]   req_ext;
  logic                run, strobe, div_load;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
  end

  assign pick = rr_pick(req_ext, rr_ptr_q, NREQ);
  assign run  = (state_q == StRun);

`ifdef CLK_BUFF_SCHED_PHASE_ALIGN_EN
  assign div_preload = div_ratio;
`else
  assign div_preload = '0;
`endif

  clk_buff_div #(
    .W (DIV_W)
  ) u_div (
    .clk_i      (master_clk),
    .rst_i      (rst),
    .load_i     (div_load),
    .load_val_i (div_preload),
    .en_i       (run),
    .limit_i    (div_r_q),
    .strobe_o   (strobe)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    div_r_d  = div_r_q;
    rem_d    = rem_q;
    grant_d  = grant_q;
    div_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d  = StRun;
          idx_d    = pick;
          grant_d  = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          div_r_d  = div_ratio;
          rem_d    = (hold_cnt == '0) ? HOLD_W'(1) : hold_cnt;
          div_load = 1'b1;
        end
      end
      StRun: begin
        if (strobe) rem_d = rem_q - HOLD_W'(1);
        // A strobe coincident with withdrawal has already been issued above.
        if ((strobe && rem_q == HOLD_W'(1)) || !req_ext[idx_q]) begin
          state_d = StDrain;
          grant_d = '0;
        end
      end
      StDrain: begin
        state_d  = StIdle;
        rr_ptr_d = (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + IdxW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      div_r_q  <= '0;
      rem_q    <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      div_r_q  <= div_r_d;
      rem_q    <= rem_d;
      grant_q  <= grant_d;
    end
  end

  assign grant       = grant_q;
  assign buff_clk_en = strobe;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDrain);

endmodule

// File: tb/tb_clk_buff_sched.sv
module tb_clk_buff_sched;

  logic       master_clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] div_ratio;
  logic [7:0] hold_cnt;
  logic [3:0] grant;
  logic       buff_clk_en, busy, done;

  int checks = 0;
  int errors = 0;

`ifdef CLK_BUFF_SCHED_PHASE_ALIGN_EN
  localparam bit PhaseAlign = 1'b1;
`else
  localparam bit PhaseAlign = 1'b0;
`endif

  clk_buff_sched #(
    .NREQ   (4),
    .DIV_W  (4),
    .HOLD_W (8)
  ) dut (
    .master_clk  (master_clk),
    .rst         (rst),
    .req         (req),
    .div_ratio   (div_ratio),
    .hold_cnt    (hold_cnt),
    .grant       (grant),
    .buff_clk_en (buff_clk_en),
    .busy        (busy),
    .done        (done)
  );

  always #5 master_clk = ~master_clk;

  // Enable strobe only while a grant is held; grant at most one-hot.
  always @(negedge master_clk) begin
    if (!rst) begin
      checks++;
      if ((buff_clk_en && (grant == 4'b0 || !busy)) || $countones(grant) > 1) begin
        errors++;
        $display("FAIL invariant: grant=%b en=%b busy=%b required one-hot grant, en only when granted",
                 grant, buff_clk_en, busy);
      end
    end
  end

  task automatic tick;
    @(posedge master_clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; div_ratio = '0; hold_cnt = '0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  // Called at the sample of RUN cycle 0; walks until done is seen.
  task automatic measure(input int drop_after, output int n_str, output int first_k,
                         output int period, output int done_k, output logic [3:0] gnt_done);
    int prev;
    n_str = 0; first_k = -1; period = -1; done_k = -1; gnt_done = 4'bx; prev = -1;
    for (int k = 0; k < 80; k++) begin
      if (done) begin
        done_k   = k;
        gnt_done = grant;
        break;
      end
      if (buff_clk_en) begin
        if (prev < 0) first_k = k;
        else if (period < 0) period = k - prev;
        else if (period != k - prev) period = -2;
        prev = k;
        n_str++;
        if (n_str == drop_after) req = '0;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; div_ratio = '0; hold_cnt = '0;
    #2;
    checks++;
    if ({grant, buff_clk_en, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000", {grant, buff_clk_en, busy, done});
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({grant, buff_clk_en, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 0000000", {grant, buff_clk_en, busy, done});
    end
  endtask

  task automatic test_single;
    int n, f, p, d;
    logic [3:0] g;
    do_reset;
    req = 4'b0010; div_ratio = 4'd2; hold_cnt = 8'd3;
    tick;
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got grant=%b busy=%b required 0010/1", grant, busy);
    end
    // Mid-RUN changes must not affect the active grant.
    div_ratio = 4'd0; hold_cnt = 8'd1;
    measure(0, n, f, p, d, g);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL single_count: got %0d required 3", n); end
    checks++;
    if (f !== (PhaseAlign ? 0 : 2)) begin
      errors++; $display("FAIL single_first: got %0d required %0d", f, PhaseAlign ? 0 : 2);
    end
    checks++;
    if (p !== 3) begin errors++; $display("FAIL single_period: got %0d required 3", p); end
    checks++;
    if (d !== (PhaseAlign ? 7 : 9) || g !== 4'b0) begin
      errors++;
      $display("FAIL single_done: got k=%0d grant=%b required k=%0d grant=0000",
               d, g, PhaseAlign ? 7 : 9);
    end
    req = '0;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL single_idle: got busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_rotate;
    logic [3:0] exp;
    do_reset;
    req = 4'b1111; div_ratio = 4'd0; hold_cnt = 8'd1;
    tick;
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      checks++;
      if (grant !== exp || buff_clk_en !== 1'b1) begin
        errors++;
        $display("FAIL rotate_grant%0d: got grant=%b en=%b required %b/1", i, grant, buff_clk_en, exp);
      end
      tick;
      checks++;
      if ({done, busy, grant} !== 6'b110000) begin
        errors++;
        $display("FAIL rotate_drain%0d: got done,busy,grant=%b required 110000", i, {done, busy, grant});
      end
      tick;
      checks++;
      if ({busy, grant} !== 5'b0) begin
        errors++;
        $display("FAIL rotate_idle%0d: got busy,grant=%b required 00000", i, {busy, grant});
      end
      tick;
    end
    req = '0;
  endtask

  task automatic test_withdraw;
    int n, f, p, d;
    logic [3:0] g;
    do_reset;
    req = 4'b0001; div_ratio = 4'd1; hold_cnt = 8'd10;
    tick;
    measure(2, n, f, p, d, g);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL withdraw_count: got %0d required 2", n); end
    checks++;
    if (d !== (PhaseAlign ? 3 : 4) || g !== 4'b0) begin
      errors++;
      $display("FAIL withdraw_done: got k=%0d grant=%b required k=%0d grant=0000",
               d, g, PhaseAlign ? 3 : 4);
    end
  endtask

  task automatic test_hold_zero;
    int n, f, p, d;
    logic [3:0] g;
    do_reset;
    req = 4'b0001; div_ratio = 4'd0; hold_cnt = 8'd0;
    tick;
    measure(0, n, f, p, d, g);
    checks++;
    if (n !== 1 || f !== 0) begin
      errors++; $display("FAIL hold0_count: got n=%0d first=%0d required 1/0", n, f);
    end
    checks++;
    if (d !== 1) begin errors++; $display("FAIL hold0_done: got %0d required 1", d); end
    req = '0;
    tick;
  endtask

  task automatic test_rst_mid_run;
    do_reset;
    req = 4'b0010; div_ratio = 4'd0; hold_cnt = 8'd1;
    tick;
    tick;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL midrst_setup_done: got %b required 1", done); end
    req = 4'b0110; hold_cnt = 8'd10;
    tick;
    tick;
    checks++;
    if (grant !== 4'b0100) begin
      errors++; $display("FAIL midrst_rr_grant: got %b required 0100", grant);
    end
    tick;
    tick;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({grant, buff_clk_en, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL midrst_async: got %b required 0000000", {grant, buff_clk_en, busy, done});
    end
    #1 rst = 1'b0;
    tick;
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL midrst_ptr_cleared: got %b required 0010", grant);
    end
    req = '0;
  endtask

  task automatic test_phase;
    int n, f, p, d;
    logic [3:0] g;
    do_reset;
    req = 4'b1000; div_ratio = 4'd3; hold_cnt = 8'd3;
    tick;
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL phase_grant: got %b required 1000", grant); end
    measure(0, n, f, p, d, g);
    checks++;
    if (f !== (PhaseAlign ? 0 : 3)) begin
      errors++; $display("FAIL phase_first: got %0d required %0d", f, PhaseAlign ? 0 : 3);
    end
    checks++;
    if (p !== 4 || n !== 3) begin
      errors++; $display("FAIL phase_period: got period=%0d n=%0d required 4/3", p, n);
    end
    req = '0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotate;
    test_withdraw;
    test_hold_zero;
    test_rst_mid_run;
    test_phase;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
